hs_tx_arbiter: RTL and testbench
================================

HS_TX_ARBITER -- requirements
Module: hs_tx_arbiter

Interface
REQ-001 Parameter: DW, 4, width of each source word and of the handshake data bus.
REQ-002 Parameter: SYNC_STAGES, 2, number of flops synchronizing data_ack (legal: 2 or 3).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports clk_a and rst.
REQ-004 clk_a  input  1  sender-domain clock; all flops on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 src_valid  input  4  per-source request; bit i = source i has a word pending.
REQ-007 src_data  input  4*DW  source words; source i at bits [i*DW +: DW].
REQ-008 src_ack  output  4  one-hot, one-cycle pulse: source i's word fully transferred.
REQ-009 data  output  DW  word to the receiving domain; registered.
REQ-010 data_req  output  1  four-phase request to the receiving domain; registered.
REQ-011 data_ack  input  1  four-phase acknowledge from the receiving domain (asynchronous).
REQ-012 grant_id  output  2  index of the source currently being served; valid while busy=1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 xfer_cnt  output  8  count of completed transfers.

Function
REQ-015 data_ack SHALL pass through SYNC_STAGES flops (ack_s) before any use; no other path from data_ack.
REQ-016 FSM states SHALL be IDLE, REQ, REL and DONE.
REQ-017 IDLE: if any src_valid bit is set, the block SHALL go to REQ on that edge and, on the same edge, latch the winner's word into data, set grant_id, and set data_req=1.
REQ-018 REQ: data_req=1 and data held stable; go to REL on the first edge with ack_s=1.
REQ-019 REL: data_req=0 and data still held; go to DONE on the first edge with ack_s=0.
REQ-020 DONE: src_ack[grant_id]=1 for exactly this one cycle; xfer_cnt increments on the edge leaving DONE (wraps 255->0); go to IDLE.
REQ-021 No timeout: REQ and REL SHALL wait indefinitely.
REQ-022 Requester rule: a source holds src_valid until it samples its src_ack; it drops or updates src_valid on the edge ending DONE.
REQ-023 Deassertion of src_valid[grant_id] after grant SHALL be ignored; the transfer completes and src_ack still pulses.
REQ-024 src_valid and src_data changes SHALL be ignored outside IDLE; arbitration occurs only in IDLE.
REQ-025 Minimum transfer length: IDLE->REQ plus SYNC_STAGES+1 cycles per ack edge plus DONE; back-to-back grants SHALL be separated by exactly one IDLE cycle.
REQ-026 src_ack SHALL be 0 in all states except DONE, and at most one bit SHALL be set.
REQ-027 Arbitration policy SHALL be selected by REQ-033/034.

Reset
REQ-028 On rst=1 at an edge the FSM SHALL go to IDLE. On the same edge: data_req=0, data=0, grant_id=0, busy=0, src_ack=0, xfer_cnt=0, all ack_s flops=0, and round-robin pointer=0.
REQ-029 Reset mid-transfer SHALL abort the transfer with no src_ack and no xfer_cnt increment; data_req SHALL be 0 on the next cycle.
REQ-030 After reset deassertion, the first grant SHALL occur no earlier than the first edge with rst=0.

Configuration
REQ-031 Macro HS_ARB_RR_EN selects the arbitration policy.
REQ-032 Policies are defined in REQ-033 (macro defined) and REQ-034 (macro undefined).
REQ-033 Defined: round-robin.
- The search starts at pointer ptr; the first set src_valid bit at index ptr, ptr+1, ... (mod 4) wins.
- On each grant, ptr <= (winner+1) mod 4.
REQ-034 Undefined: fixed priority, lowest index wins; no pointer flops are present.

Verification
REQ-035 Single source: src_valid=4'b0100, src_data[11:8]=4'hA, data_ack loops back data_req with 3-cycle delay -> data=4'hA, grant_id=2, src_ack=4'b0100 pulse once, xfer_cnt=1.
REQ-036 Contention: src_valid=4'b1011 held, each source drops on its ack, HS_ARB_RR_EN defined -> grant order 0,1,3. Repeat with the macro undefined -> order 0,1,3. Then with sources 0 and 1 re-requesting immediately: RR order 0,1,3,0,1; fixed-priority starves 3.
REQ-037 Stability: during REQ/REL, toggle src_data[3:0] 4'h5->4'hF and drop src_valid[0] -> data stays 4'h5 until IDLE; src_ack[0] still pulses.
REQ-038 Stalled ack: hold data_ack=0 for 100 cycles -> data_req stays 1, busy=1, no src_ack. Then raise ack -> REL after SYNC_STAGES+1 cycles.
REQ-039 Reset in REL: assert rst for 1 cycle -> next cycle data_req=0, busy=0, xfer_cnt unchanged from pre-transfer 0, no src_ack pulse.
REQ-040 Wrap: 256 completed transfers -> xfer_cnt returns to 0.

Source files
------------

// File: rtl/hs_tx_arbiter.sv
// Four-source arbiter feeding a four-phase req/ack handshake into another domain.
// Define HS_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module hs_tx_arbiter #(
    parameter int DW          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_a,
    input  logic            rst,
    input  logic [3:0]      src_valid,
    input  logic [4*DW-1:0] src_data,
    output logic [3:0]      src_ack,
    output logic [DW-1:0]   data,
    output logic            data_req,
    input  logic            data_ack,
    output logic [1:0]      grant_id,
    output logic            busy,
    output logic [7:0]      xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [1:0]             win_id;
    logic [DW-1:0]          words [4];

    assign ack_s = ack_sync[SYNC_STAGES-1];

    for (genvar i = 0; i < 4; i++) begin : g_word
        assign words[i] = src_data[i*DW +: DW];
    end

    always_ff @(posedge clk_a) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], data_ack};
        end
    end

`ifdef HS_ARB_RR_EN
    logic [1:0] ptr;
    logic [1:0] idx;

    // Scan downward so the candidate nearest ptr is assigned last and wins.
    always_comb begin
        win_id = '0;
        idx    = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (src_valid[idx]) begin
                win_id = idx;
            end
        end
    end

    always_ff @(posedge clk_a) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == IDLE && |src_valid) begin
            ptr <= win_id + 2'd1;
        end
    end
`else
    always_comb begin
        win_id = '0;
        for (int k = 3; k >= 0; k--) begin
            if (src_valid[k]) begin
                win_id = 2'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk_a) begin
        if (rst) begin
            state    <= IDLE;
            data_req <= 1'b0;
            data     <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            src_ack  <= '0;
            xfer_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|src_valid) begin
                        state    <= REQ;
                        data     <= words[win_id];
                        grant_id <= win_id;
                        data_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        state    <= REL;
                        data_req <= 1'b0;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        state   <= DONE;
                        src_ack <= 4'b0001 << grant_id;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    src_ack  <= '0;
                    busy     <= 1'b0;
                    xfer_cnt <= xfer_cnt + 8'd1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_tx_arbiter.sv
// Scoreboard bench for hs_tx_arbiter with a looped-back four-phase receiver.
// Grant-order expectations follow HS_ARB_RR_EN the same way the design does.
module tb_hs_tx_arbiter;

    localparam int DW          = 4;
    localparam int SYNC_STAGES = 2;

    logic            clk_a = 1'b0;
    logic            rst;
    logic [3:0]      src_valid;
    logic [4*DW-1:0] src_data;
    logic [3:0]      src_ack;
    logic [DW-1:0]   data;
    logic            data_req;
    logic            data_ack;
    logic [1:0]      grant_id;
    logic            busy;
    logic [7:0]      xfer_cnt;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] d;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         want[4] = '{default: 0};
    int         got[4]  = '{default: 0};
    logic [3:0] drop;
    bit         resp_en;
    logic [2:0] dly;
    int         ack_events = 0;
    logic [7:0] exp_cnt;

    hs_tx_arbiter #(
        .DW          (DW),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_a     (clk_a),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ack   (src_ack),
        .data      (data),
        .data_req  (data_req),
        .data_ack  (data_ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk_a = ~clk_a;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Receiver: data_ack follows data_req three cycles later.
    initial begin
        data_ack = 1'b0;
        dly      = '0;
        forever begin
            @(posedge clk_a);
            #1;
            dly      = {dly[1:0], data_req};
            data_ack = resp_en ? dly[2] : 1'b0;
        end
    end

    // Sources and scoreboard: each source requests until want[] acks arrive.
    initial begin
        src_valid = '0;
        forever begin
            @(posedge clk_a);
            #1;
            if (src_ack != '0) begin
                ack_events++;
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(src_ack), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("src_ack", 32'(src_ack), 32'(4'b0001 << e.id));
                    chk("grant_id", 32'(grant_id), 32'(e.id));
                    chk("data", 32'(data), 32'(e.d));
                end
                for (int i = 0; i < 4; i++) begin
                    if (src_ack[i]) got[i]++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                src_valid[i] = (want[i] > got[i]) && !drop[i];
            end
        end
    end

    task automatic expect_grant(input int i);
        exp_t e;
        e.id = 2'(i);
        e.d  = src_data[i*DW +: DW];
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk_a);
            n++;
        end
        chk("drain_sb", sb.size(), 32'h0);
        chk("drain_busy", 32'(busy), 32'h0);
        chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!busy && n < budget) begin
            @(negedge clk_a);
            n++;
        end
        chk("wait_busy", 32'(busy), 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk_a);
        rst = 1'b1;
        @(negedge clk_a);
        rst     = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        int n;
        int n0;
        rst      = 1'b1;
        src_data = {4'h9, 4'hA, 4'h8, 4'h7};
        drop     = '0;
        resp_en  = 1'b1;
        exp_cnt  = '0;
        repeat (3) @(negedge clk_a);
        chk("rst_data_req", 32'(data_req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_src_ack", 32'(src_ack), 32'h0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        rst = 1'b0;

        // single source 2
        want[2]++;
        expect_grant(2);
        exp_cnt = exp_cnt + 8'd1;
        drain(200);
        chk("single_data", 32'(data), 32'hA);
        chk("single_grant", 32'(grant_id), 32'h2);

        // contention 1011, one word each
        do_reset();
        want[0]++;
        want[1]++;
        want[3]++;
        expect_grant(0);
        expect_grant(1);
        expect_grant(3);
        exp_cnt = exp_cnt + 8'd3;
        drain(300);

        // sources 0 and 1 re-request immediately
        want[0] += 2;
        want[1] += 2;
        want[3]++;
`ifdef HS_ARB_RR_EN
        expect_grant(0);
        expect_grant(1);
        expect_grant(3);
        expect_grant(0);
        expect_grant(1);
`else
        expect_grant(0);
        expect_grant(0);
        expect_grant(1);
        expect_grant(1);
        expect_grant(3);
`endif
        exp_cnt = exp_cnt + 8'd5;
        drain(500);

        // data held while the source changes its word and withdraws
        src_data[3:0] = 4'h5;
        want[0]++;
        expect_grant(0);
        exp_cnt = exp_cnt + 8'd1;
        wait_busy(20);
        src_data[3:0] = 4'hF;
        drop[0]       = 1'b1;
        @(negedge clk_a);
        chk("stable_data", 32'(data), 32'h5);
        drain(200);
        drop[0] = 1'b0;

        // stalled acknowledge
        resp_en = 1'b0;
        want[1]++;
        expect_grant(1);
        exp_cnt = exp_cnt + 8'd1;
        wait_busy(20);
        n0 = ack_events;
        repeat (100) @(negedge clk_a);
        chk("stall_req", 32'(data_req), 32'h1);
        chk("stall_busy", 32'(busy), 32'h1);
        chk("stall_src_ack", 32'(src_ack), 32'h0);
        chk("stall_acks", ack_events, n0);
        resp_en = 1'b1;
        n = 0;
        while (!data_ack && n < 10) begin
            @(negedge clk_a);
            n++;
        end
        chk("stall_ack_seen", 32'(data_ack), 32'h1);
        n = 0;
        while (data_req && n < 20) begin
            @(negedge clk_a);
            n++;
        end
        chk("rel_latency", n, SYNC_STAGES + 1);
        drain(200);

        // reset while in REL
        do_reset();
        want[2]++;
        wait_busy(20);
        drop[2] = 1'b1;
        n = 0;
        while (!(busy && !data_req) && n < 40) begin
            @(negedge clk_a);
            n++;
        end
        chk("in_rel", {30'h0, busy, data_req}, 32'h2);
        n0  = ack_events;
        rst = 1'b1;
        @(negedge clk_a);
        rst = 1'b0;
        chk("relrst_req", 32'(data_req), 32'h0);
        chk("relrst_busy", 32'(busy), 32'h0);
        chk("relrst_src_ack", 32'(src_ack), 32'h0);
        chk("relrst_cnt", 32'(xfer_cnt), 32'h0);
        repeat (20) @(negedge clk_a);
        chk("relrst_acks", ack_events, n0);
        chk("relrst_idle", 32'(busy), 32'h0);
        chk("relrst_cnt2", 32'(xfer_cnt), 32'h0);

        // counter wrap
        for (int i = 0; i < 255; i++) begin
            want[3]++;
            expect_grant(3);
        end
        exp_cnt = exp_cnt + 8'd255;
        drain(8000);
        want[3]++;
        expect_grant(3);
        exp_cnt = exp_cnt + 8'd1;
        drain(100);
        chk("wrap_cnt", 32'(xfer_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
